// File: rtl/sad_accum_pkg.sv
// sad_accum_pkg: shared defaults, width helper and stage-1 control record
// for the sad_accum reduction pipeline.
package sad_accum_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_LANES     = 4;
  localparam int unsigned DEF_ACC_WIDTH = 24;
  localparam bit          DEF_SIGNED    = 1'b0;

  // Width of the per-beat lane sum: one WIDTH-bit magnitude per lane,
  // so log2(LANES) carry bits are enough to never overflow.
  function automatic int unsigned lane_sum_width(input int unsigned width,
                                                 input int unsigned lanes);
    return width + $clog2(lanes);
  endfunction

  // Control half of the stage-1 record; the diffs half is sized by the
  // instantiating module's parameters and joined to this in sad_accum.
  typedef struct packed {
    logic last;
    logic valid;
  } s1_ctrl_t;

endpackage

// File: rtl/sad_accum_abs_diff_lane.sv
// abs_diff_lane: registered |a - b| for one lane. With SIGNED set, operands
// are two's complement and are sign-extended by one bit before subtracting;
// the magnitude always fits in WIDTH bits.
module abs_diff_lane #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d
);

  logic [WIDTH:0]   a_x;
  logic [WIDTH:0]   b_x;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] mag;

  // Extend, subtract, and fold negative differences to their magnitude.
  // The low bits of a negation depend only on the low bits of the operand,
  // so the sign bit is consumed only as the select.
  always_comb begin
    a_x  = SIGNED ? {a[WIDTH-1], a} : {1'b0, a};
    b_x  = SIGNED ? {b[WIDTH-1], b} : {1'b0, b};
    diff = a_x - b_x;
    mag  = diff[WIDTH] ? (~diff[WIDTH-1:0] + WIDTH'(1)) : diff[WIDTH-1:0];
  end

  // Capture the magnitude when a beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0;
    end else if (en) begin
      d <= mag;
    end
  end

endmodule

// File: rtl/sad_accum.sv
// sad_accum: pipelined multi-lane sum-of-absolute-differences accumulator.
// Stage 1 registers per-lane |in_0 - in_1|, stage 2 registers the lane sum,
// stage 3 accumulates over a frame and publishes one result per frame on a
// valid/ready output. A stalled output freezes every stage.
// Optional build macro: SAD_ACCUM_SATURATE_EN (clamp accumulate to all-ones
// instead of wrapping modulo 2^ACC_WIDTH).
module sad_accum
  import sad_accum_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter bit          SIGNED    = DEF_SIGNED
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*WIDTH-1:0] in_0,
  input  logic [LANES*WIDTH-1:0] in_1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   res
);

  localparam int unsigned LSW  = lane_sum_width(WIDTH, LANES);
  localparam int unsigned ACW1 = ACC_WIDTH + 1;

  if (LANES < 1 || LANES > 16 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("sad_accum: LANES=%0d must be a power of two in 1..16", LANES);
  end

  if (ACC_WIDTH < LSW) begin : g_bad_acc_width
    $error("sad_accum: ACC_WIDTH=%0d must be >= %0d", ACC_WIDTH, LSW);
  end

  typedef struct packed {
    logic [LANES*WIDTH-1:0] diffs;
    s1_ctrl_t               ctrl;
  } s1_rec_t;

  logic                   advance;
  logic                   accept;
  logic [LANES*WIDTH-1:0] s1_diffs;
  s1_ctrl_t               s1_ctrl;
  s1_rec_t                s1;
  logic [LSW-1:0]         lane_sum_c;
  logic                   s2_valid;
  logic                   s2_last;
  logic [LSW-1:0]         s2_sum;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH:0]     acc_sum;
  logic [ACC_WIDTH-1:0]   acc_next;

  // The whole pipeline moves only when the output register can be vacated.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Stage 1 datapath: one registered absolute-difference unit per lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    abs_diff_lane #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .a     (in_0[g*WIDTH +: WIDTH]),
      .b     (in_1[g*WIDTH +: WIDTH]),
      .d     (s1_diffs[g*WIDTH +: WIDTH])
    );
  end

  // Stage 1 control: valid and last travel with the beat's diffs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctrl <= '0;
    end else if (advance) begin
      s1_ctrl.valid <= in_valid;
      s1_ctrl.last  <= in_valid && in_last;
    end
  end

  assign s1 = '{diffs: s1_diffs, ctrl: s1_ctrl};

  // Lane reduction; the widened sum cannot overflow.
  always_comb begin
    lane_sum_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_sum_c = lane_sum_c + LSW'(s1.diffs[i*WIDTH +: WIDTH]);
    end
  end

  // Stage 2: register the lane sum with its control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
    end else if (advance) begin
      s2_valid <= s1.ctrl.valid;
      s2_last  <= s1.ctrl.last;
      s2_sum   <= lane_sum_c;
    end
  end

  // Accumulate with one spare carry bit, then wrap or clamp. A clamped
  // accumulator is all-ones, so any later non-negative add overflows again
  // or leaves it unchanged: clamping stays sticky without a separate flag.
  always_comb begin
    acc_sum = {1'b0, acc} + ACW1'(s2_sum);
`ifdef SAD_ACCUM_SATURATE_EN
    acc_next = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
    acc_next = acc_sum[ACC_WIDTH-1:0];
`endif
  end

  // Stage 3: frame accumulation and result publication. When advancing
  // with out_valid high, out_ready must be high, so the old result is
  // consumed on this edge and out_valid follows only a new frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      res       <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        if (s2_last) begin
          res <= acc_next;
          acc <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_accum.sv
// Directed bench for sad_accum: an unsigned 24-bit instance, a signed
// 24-bit instance and an unsigned 10-bit instance share one stimulus stream.
module tb_sad_accum;

  localparam int W = 8;
  localparam int L = 4;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic           in_last   = 1'b0;
  logic           out_ready = 1'b1;
  logic [L*W-1:0] in_0      = '0;
  logic [L*W-1:0] in_1      = '0;

  logic        rdy0, rdys, rdya;
  logic        ov0, ovs, ova;
  logic [23:0] res0, ress;
  logic [9:0]  resa;

  int vectors     = 0;
  int miscompares = 0;

  logic [23:0] q0[$];
  logic [23:0] qs[$];
  logic [9:0]  qa[$];

  always #5 clk = ~clk;

  sad_accum #(.WIDTH(8), .LANES(4), .ACC_WIDTH(24), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_last(in_last),
    .in_0(in_0), .in_1(in_1), .out_valid(ov0), .out_ready(out_ready), .res(res0));

  sad_accum #(.WIDTH(8), .LANES(4), .ACC_WIDTH(24), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdys), .in_last(in_last),
    .in_0(in_0), .in_1(in_1), .out_valid(ovs), .out_ready(out_ready), .res(ress));

  sad_accum #(.WIDTH(8), .LANES(4), .ACC_WIDTH(10), .SIGNED(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdya), .in_last(in_last),
    .in_0(in_0), .in_1(in_1), .out_valid(ova), .out_ready(out_ready), .res(resa));

  // Record every result that is handed off on the coming edge.
  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (ov0) q0.push_back(res0);
      if (ovs) qs.push_back(ress);
      if (ova) qa.push_back(resa);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pk(input int x0, input int x1, input int x2, input int x3);
    return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
  endfunction

  task automatic clear_q();
    q0.delete();
    qs.delete();
    qa.delete();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a beat and return 1 time unit after the edge that accepts it.
  // in_valid is left high so consecutive calls are back-to-back.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    bit ok;
    ok       = 1'b0;
    in_0     = a;
    in_1     = b;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      ok = rdy0;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%0b required 1 within 50 cycles", rdy0);
    end
  endtask

  task automatic wait_results(output logic [23:0] r0, output logic [23:0] rs, output logic [9:0] ra);
    int n;
    n = 0;
    while ((q0.size() == 0 || qs.size() == 0 || qa.size() == 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q0.size() == 0 || qs.size() == 0 || qa.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL result_timeout: queued %0d/%0d/%0d required at least 1 each",
               q0.size(), qs.size(), qa.size());
      r0 = 'x;
      rs = 'x;
      ra = 'x;
    end else begin
      r0 = q0.pop_front();
      rs = qs.pop_front();
      ra = qa.pop_front();
    end
  endtask

  task automatic test_reset();
    logic [23:0] r0, rs;
    logic [9:0]  ra;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    #1;
    vectors++; if (rdy0 !== 1'b1 || rdys !== 1'b1 || rdya !== 1'b1) begin miscompares++;
      $display("FAIL reset_in_ready: got %0b%0b%0b required 111", rdy0, rdys, rdya); end
    vectors++; if (ov0 !== 1'b0 || ovs !== 1'b0 || ova !== 1'b0) begin miscompares++;
      $display("FAIL reset_out_valid: got %0b%0b%0b required 000", ov0, ovs, ova); end
    vectors++; if (res0 !== 24'd0) begin miscompares++;
      $display("FAIL reset_res: got %0d required 0", res0); end
    // two beats of a three-beat frame, then reset while they are in flight
    send_beat(pk(4, 4, 4, 4), pk(1, 1, 1, 1), 1'b0);
    send_beat(pk(4, 4, 4, 4), pk(1, 1, 1, 1), 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    vectors++; if (ov0 !== 1'b0) begin miscompares++;
      $display("FAIL reset_mid_out_valid: got %0b required 0", ov0); end
    idle(2);
    rst_n = 1'b1;
    #1;
    vectors++; if (rdy0 !== 1'b1) begin miscompares++;
      $display("FAIL reset_mid_in_ready: got %0b required 1", rdy0); end
    vectors++; if (ov0 !== 1'b0 || res0 !== 24'd0) begin miscompares++;
      $display("FAIL reset_mid_out: out_valid=%0b res=%0d required 0/0", ov0, res0); end
    clear_q();
    send_beat(pk(2, 2, 2, 2), pk(1, 1, 1, 1), 1'b1);
    idle(0);
    wait_results(r0, rs, ra);
    vectors++; if (r0 !== 24'd4) begin miscompares++;
      $display("FAIL reset_discard: got %0d required 4", r0); end
    idle(3);
    clear_q();
  endtask

  task automatic test_single();
    send_beat(pk(10, 200, 0, 255), pk(20, 100, 0, 0), 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    vectors++; if (ov0 !== 1'b0) begin miscompares++;
      $display("FAIL single_lat0: out_valid=%0b required 0", ov0); end
    @(posedge clk); #1;
    vectors++; if (ov0 !== 1'b0) begin miscompares++;
      $display("FAIL single_lat1: out_valid=%0b required 0", ov0); end
    @(posedge clk); #1;
    vectors++; if (ov0 !== 1'b1 || res0 !== 24'd365) begin miscompares++;
      $display("FAIL single_lat2: out_valid=%0b res=%0d required 1/365", ov0, res0); end
    vectors++; if (ress !== 24'd167) begin miscompares++;
      $display("FAIL single_signed: got %0d required 167", ress); end
    vectors++; if (resa !== 10'd365) begin miscompares++;
      $display("FAIL single_acc10: got %0d required 365", resa); end
    @(posedge clk); #1;
    vectors++; if (ov0 !== 1'b0) begin miscompares++;
      $display("FAIL single_clear: out_valid=%0b required 0", ov0); end
    idle(2);
    clear_q();
  endtask

  task automatic test_back_to_back();
    logic [23:0] r0, rs;
    logic [9:0]  ra;
    send_beat(pk(2, 2, 2, 2), pk(1, 1, 1, 1), 1'b0);
    send_beat(pk(1, 1, 1, 1), pk(2, 2, 2, 2), 1'b0);
    send_beat(pk(9, 8, 7, 6), pk(8, 7, 6, 5), 1'b1);
    send_beat(pk(5, 5, 5, 5), pk(0, 0, 0, 0), 1'b1);
    idle(0);
    wait_results(r0, rs, ra);
    vectors++; if (r0 !== 24'd12) begin miscompares++;
      $display("FAIL b2b_first: got %0d required 12", r0); end
    vectors++; if (rs !== 24'd12) begin miscompares++;
      $display("FAIL b2b_first_signed: got %0d required 12", rs); end
    wait_results(r0, rs, ra);
    vectors++; if (r0 !== 24'd20) begin miscompares++;
      $display("FAIL b2b_second: got %0d required 20", r0); end
    vectors++; if (ra !== 10'd20) begin miscompares++;
      $display("FAIL b2b_second_acc10: got %0d required 20", ra); end
    idle(5);
    vectors++; if (q0.size() !== 0) begin miscompares++;
      $display("FAIL b2b_extra: got %0d extra results required 0", q0.size()); end
    clear_q();
  endtask

  task automatic test_backpressure();
    logic [23:0] r0, rs;
    logic [9:0]  ra;
    out_ready = 1'b0;
    send_beat(pk(10, 200, 0, 255), pk(20, 100, 0, 0), 1'b1);
    send_beat(pk(3, 3, 3, 3), pk(1, 1, 1, 1), 1'b0);
    send_beat(pk(1, 1, 1, 1), pk(3, 3, 3, 3), 1'b1);
    // third frame held on the inputs while the output is stalled
    in_0     = pk(8, 8, 8, 8);
    in_1     = pk(1, 1, 1, 1);
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (rdy0 !== 1'b0 || ov0 !== 1'b1 || res0 !== 24'd365) begin miscompares++;
        $display("FAIL bp_hold[%0d]: in_ready=%0b out_valid=%0b res=%0d required 0/1/365",
                 i, rdy0, ov0, res0); end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_beat(pk(8, 8, 8, 8), pk(1, 1, 1, 1), 1'b1);
    idle(0);
    wait_results(r0, rs, ra);
    vectors++; if (r0 !== 24'd365) begin miscompares++;
      $display("FAIL bp_first: got %0d required 365", r0); end
    wait_results(r0, rs, ra);
    vectors++; if (r0 !== 24'd16) begin miscompares++;
      $display("FAIL bp_second: got %0d required 16", r0); end
    wait_results(r0, rs, ra);
    vectors++; if (r0 !== 24'd28) begin miscompares++;
      $display("FAIL bp_third: got %0d required 28", r0); end
    idle(5);
    vectors++; if (q0.size() !== 0) begin miscompares++;
      $display("FAIL bp_extra: got %0d extra results required 0", q0.size()); end
    clear_q();
  endtask

  task automatic test_signed();
    logic [23:0] r0, rs;
    logic [9:0]  ra;
    send_beat(pk(8'h80, 3, 4, 5), pk(8'h7F, 3, 4, 5), 1'b1);
    idle(0);
    wait_results(r0, rs, ra);
    vectors++; if (rs !== 24'd255) begin miscompares++;
      $display("FAIL signed_extreme: got %0d required 255", rs); end
    vectors++; if (r0 !== 24'd1) begin miscompares++;
      $display("FAIL signed_as_unsigned: got %0d required 1", r0); end
    idle(3);
    clear_q();
  endtask

  task automatic test_overflow();
    logic [23:0] r0, rs;
    logic [9:0]  ra;
    logic [9:0]  exp_a;
`ifdef SAD_ACCUM_SATURATE_EN
    exp_a = 10'd1023;
`else
    exp_a = 10'd1004;
`endif
    for (int i = 0; i < 5; i++) begin
      send_beat(pk(255, 255, 255, 255), pk(0, 0, 0, 0), (i == 4));
    end
    send_beat(pk(1, 1, 1, 1), pk(0, 0, 0, 0), 1'b1);
    idle(0);
    wait_results(r0, rs, ra);
    vectors++; if (ra !== exp_a) begin miscompares++;
      $display("FAIL ovf_acc10: got %0d required %0d", ra, exp_a); end
    vectors++; if (r0 !== 24'd5100) begin miscompares++;
      $display("FAIL ovf_acc24: got %0d required 5100", r0); end
    vectors++; if (rs !== 24'd20) begin miscompares++;
      $display("FAIL ovf_signed: got %0d required 20", rs); end
    wait_results(r0, rs, ra);
    vectors++; if (ra !== 10'd4) begin miscompares++;
      $display("FAIL ovf_restart: got %0d required 4", ra); end
    idle(3);
    clear_q();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_signed();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
